rr_replay_bus_group2_reg: RTL
=============================

RR_REPLAY_BUS_GROUP2_REG -- requirements
Module: rr_replay_bus_group2_reg

Interface
REQ-001 Parameters SHALL be as follows:
  - CNT_A, default 4: number of side-A channels.
  - CNT_B, default 4: number of side-B channels.
  - DW_A, default 512: packed side-A data width.
  - DW_B, default 512: packed side-B data width.
REQ-002 CNT = CNT_A+CNT_B and DW = DW_A+DW_B SHALL be derived localparams.
REQ-003 Generate-time $error SHALL fire if any of CNT_A, CNT_B, DW_A or DW_B is 0.
REQ-004 Ports SHALL be as follows, clock and reset first:
  - clk  in  1  sole clock.
  - rst_n  in  1  asynchronous active-low reset.
  - a_valid / a_logb_valid / a_loge_valid  in  CNT_A each  side-A replay strobes.
  - a_logb_data  in  DW_A  side-A packed data.
  - a_almful  out  CNT_A  almost-full back to side A.
  - b_valid / b_logb_valid / b_loge_valid  in  CNT_B each  side-B replay strobes.
  - b_logb_data  in  DW_B  side-B packed data.
  - b_almful  out  CNT_B  almost-full back to side B.
  - o_valid / o_logb_valid / o_loge_valid  out  CNT  merged strobes.
  - o_logb_data  out  DW  merged data.
  - o_almful  in  CNT  almost-full from merged consumer.
  - cnt_clr  in  1  synchronous clear of counters and error state.
  - a_beats / b_beats  out  32 each  beat counters.
  - proto_err  out  1  sticky protocol error flag.
  - err_chan  out  $clog2(CNT)  channel index of the first error.

Function
REQ-005 Merge placement: side A SHALL occupy the low end of the merged bus and side B the high end:
  - strobe bits [0 +: CNT_A] = A, [CNT_A +: CNT_B] = B;
  - data [0 +: DW_A] = A, [DW_A +: DW_B] = B.
REQ-006 Forward path: o_valid, o_logb_valid, o_loge_valid and o_logb_data SHALL be registered, with exactly 1 cycle of latency from the inputs.
REQ-007 The forward path SHALL NOT stall: every input cycle SHALL appear on the output exactly one cycle later, with no drop or reorder.
REQ-008 o_logb_data SHALL load only in cycles where at least one input valid bit is set, and SHALL hold otherwise.
REQ-009 Strobe outputs SHALL be 0 in any cycle that follows an input cycle with no valid bits set.
REQ-010 Backward path: o_almful[CNT_A-1:0] SHALL be registered onto a_almful, and o_almful[CNT-1:CNT_A] onto b_almful, with 1 cycle of latency.
REQ-011 The almful path is advisory only: the block SHALL NOT gate valid with it.
REQ-012 Consumers SHALL reserve at least 2 entries of headroom beyond their almful threshold; this requirement is stated here for integrators.
REQ-013 Beat counters: a_beats SHALL increment by 1 in each cycle with |a_valid, and b_beats in each cycle with |b_valid.
REQ-014 The beat counters SHALL saturate at 32'hFFFF_FFFF.
REQ-015 Per-channel protocol checker: there SHALL be one FSM per merged channel with states IDLE and OPEN, evaluated on the registered outputs.
REQ-016 In IDLE, the checker transitions SHALL be:
  - valid&logb_valid&~loge_valid -> OPEN;
  - valid&logb_valid&loge_valid -> stay in IDLE (single-beat record);
  - valid&loge_valid&~logb_valid -> error, stay in IDLE.
REQ-017 In OPEN, the checker transitions SHALL be:
  - valid&loge_valid&~logb_valid -> IDLE;
  - valid&logb_valid -> error, stay in OPEN.
REQ-018 A logb_valid or loge_valid bit without the matching valid bit SHALL be an error in any state.
REQ-019 Error reporting: the first error SHALL set proto_err to 1 and latch the channel index into err_chan.
REQ-020 If several channels err in the same cycle, err_chan SHALL capture the lowest index.
REQ-021 While proto_err is 1, later errors SHALL NOT change err_chan.
REQ-022 cnt_clr SHALL do all of the following on the next edge:
  - zero a_beats and b_beats;
  - zero proto_err and err_chan;
  - return all checker FSMs to IDLE.
REQ-023 cnt_clr SHALL have priority over increments and errors in the same cycle.
REQ-024 cnt_clr SHALL NOT affect the forward or backward data paths.

Reset
REQ-025 While rst_n = 0, the following SHALL be 0 asynchronously:
  - all strobe outputs, a_almful and b_almful;
  - a_beats, b_beats, proto_err and err_chan;
  - all checker FSMs (IDLE).
REQ-026 o_logb_data SHALL reset to 0.
REQ-027 Reset deassertion SHALL be synchronised by the integrator; the first valid edge after deassertion SHALL behave as a normal cycle.
REQ-028 Reset asserted mid-record SHALL discard the OPEN state, with no error raised.

Verification
REQ-029 Test: CNT_A=CNT_B=2, DW_A=DW_B=8; drive a_valid=01, a_logb_data=8'hAA, b_valid=10, b_logb_data=8'h55 -> next cycle o_valid=4'b1001 and o_logb_data=16'h55AA.
REQ-030 Test: o_almful=4'b0110 for one cycle -> exactly one cycle later a_almful=2'b10 and b_almful=2'b01, then both return to 0.
REQ-031 Test: on channel 0 drive logb (cycle 0), valid-only (cycle 1), loge (cycle 2) -> proto_err stays 0 and the FSM returns to IDLE.
REQ-032 Test: drive loge_valid on channel 3 from IDLE, then logb on channel 1 while OPEN -> proto_err=1 and err_chan=3, unchanged by the second error.
REQ-033 Test: 10 cycles of a_valid!=0 with cnt_clr asserted on cycle 5 -> a_beats=4 after cycle 9.
REQ-034 Test: rst_n low for one cycle while channel 2 is OPEN -> all outputs 0; a following loge on channel 2 flags err_chan=2.

Source files
------------

// File: rtl/rr_replay_bus_group2_reg.sv
// rtl/rr_replay_bus_group2_reg.sv - two-sided replay bus merge register with beat counters and protocol checker
module rr_replay_bus_group2_reg #(
  parameter int CNT_A = 4,
  parameter int CNT_B = 4,
  parameter int DW_A  = 512,
  parameter int DW_B  = 512,
  localparam int CNT  = CNT_A + CNT_B,
  localparam int DW   = DW_A + DW_B,
  localparam int EW   = (CNT > 1) ? $clog2(CNT) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_A-1:0] a_valid,
  input  logic [CNT_A-1:0] a_logb_valid,
  input  logic [CNT_A-1:0] a_loge_valid,
  input  logic [DW_A-1:0]  a_logb_data,
  output logic [CNT_A-1:0] a_almful,
  input  logic [CNT_B-1:0] b_valid,
  input  logic [CNT_B-1:0] b_logb_valid,
  input  logic [CNT_B-1:0] b_loge_valid,
  input  logic [DW_B-1:0]  b_logb_data,
  output logic [CNT_B-1:0] b_almful,
  output logic [CNT-1:0]   o_valid,
  output logic [CNT-1:0]   o_logb_valid,
  output logic [CNT-1:0]   o_loge_valid,
  output logic [DW-1:0]    o_logb_data,
  input  logic [CNT-1:0]   o_almful,
  input  logic             cnt_clr,
  output logic [31:0]      a_beats,
  output logic [31:0]      b_beats,
  output logic             proto_err,
  output logic [EW-1:0]    err_chan
);

  if (CNT_A == 0 || CNT_B == 0 || DW_A == 0 || DW_B == 0) begin : g_bad_param
    $error("rr_replay_bus_group2_reg: CNT_A, CNT_B, DW_A and DW_B must all be non-zero");
  end

  typedef enum logic {IDLE = 1'b0, OPEN = 1'b1} state_t;

  logic [CNT-1:0] in_valid;
  logic           any_valid;
  state_t         state_q [CNT];
  state_t         state_d [CNT];
  logic [CNT-1:0] chan_err;
  logic [EW-1:0]  err_idx;

  assign in_valid  = {b_valid, a_valid};
  assign any_valid = |in_valid;

  // Strobes are squashed in idle input cycles; data only moves on live cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid      <= '0;
      o_logb_valid <= '0;
      o_loge_valid <= '0;
      o_logb_data  <= '0;
      a_almful     <= '0;
      b_almful     <= '0;
    end else begin
      o_valid      <= in_valid;
      o_logb_valid <= any_valid ? {b_logb_valid, a_logb_valid} : '0;
      o_loge_valid <= any_valid ? {b_loge_valid, a_loge_valid} : '0;
      if (any_valid) o_logb_data <= {b_logb_data, a_logb_data};
      a_almful     <= o_almful[CNT_A-1:0];
      b_almful     <= o_almful[CNT-1:CNT_A];
    end
  end

  always_comb begin
    chan_err = '0;
    for (int i = 0; i < CNT; i++) begin
      state_d[i]  = state_q[i];
      chan_err[i] = (o_logb_valid[i] | o_loge_valid[i]) & ~o_valid[i];
      if (o_valid[i]) begin
        case (state_q[i])
          IDLE: begin
            if (o_logb_valid[i] && !o_loge_valid[i]) state_d[i] = OPEN;
            else if (o_loge_valid[i] && !o_logb_valid[i]) chan_err[i] = 1'b1;
          end
          OPEN: begin
            if (o_logb_valid[i]) chan_err[i] = 1'b1;
            else if (o_loge_valid[i]) state_d[i] = IDLE;
          end
          default: state_d[i] = IDLE;
        endcase
      end
    end
  end

  // Descending scan so the lowest erring channel wins.
  always_comb begin
    err_idx = '0;
    for (int i = CNT - 1; i >= 0; i--) begin
      if (chan_err[i]) err_idx = EW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CNT; i++) state_q[i] <= IDLE;
      a_beats   <= '0;
      b_beats   <= '0;
      proto_err <= 1'b0;
      err_chan  <= '0;
    end else if (cnt_clr) begin
      for (int i = 0; i < CNT; i++) state_q[i] <= IDLE;
      a_beats   <= '0;
      b_beats   <= '0;
      proto_err <= 1'b0;
      err_chan  <= '0;
    end else begin
      for (int i = 0; i < CNT; i++) state_q[i] <= state_d[i];
      if (|a_valid && a_beats != 32'hFFFF_FFFF) a_beats <= a_beats + 32'd1;
      if (|b_valid && b_beats != 32'hFFFF_FFFF) b_beats <= b_beats + 32'd1;
      if (!proto_err && |chan_err) begin
        proto_err <= 1'b1;
        err_chan  <= err_idx;
      end
    end
  end

endmodule
